vin_pwmscan: RTL

// Round-robin scheduler sharing one period/high-time measurement counter across CHANNELS PWM inputs.
// - Per channel, in turn: synchronise input, wait for a rising edge, measure high time and period over one cycle.
// - Stores each result in a per-channel bank and moves to the next channel.
// - Sits between the raw PWM input pins and the RIO register interface.

---
 rtl/vin_pwmscan.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vin_pwmscan.sv
// vin_pwmscan
//   Round-robin PWM input scanner. A single 32-bit counter is shared by all
//   channels. Each channel in turn is synchronised and edge-detected. The
//   scanner then times one full PWM cycle (rise -> fall -> rise) and stores
//   the high time and period into that channel's bank. It then moves on to
//   the next channel.
//
// Ports
//   clk        system clock (posedge)
//   rst        asynchronous active-high reset
//   enable     1 = scan runs, 0 = park in IDLE (partial result dropped)
//   SIGNALS    raw asynchronous PWM inputs, bit i = channel i
//   period     per-channel period in clk cycles, channel i at [32*i +: 32]
//   width      per-channel high time in clk cycles, same packing
//   valid      bit i set once channel i holds a stored result
//   tmo        bit i = last result of channel i was a timeout
//   active_ch  channel currently owning the counter
//   done       one-cycle pulse while a result is being stored
//   done_ch    channel index being stored, valid while done = 1
module vin_pwmscan #(
    parameter int          CHANNELS = 4,
    parameter logic [31:0] TIMEOUT  = 32'd25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [CHANNELS-1:0]     SIGNALS,
    output logic [32*CHANNELS-1:0]  period,
    output logic [32*CHANNELS-1:0]  width,
    output logic [CHANNELS-1:0]     valid,
    output logic [CHANNELS-1:0]     tmo,
    output logic [3:0]              active_ch,
    output logic                    done,
    output logic [3:0]              done_ch
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_ARM, S_HIGH, S_LOW, S_STORE
    } state_t;

    localparam logic [3:0] LAST_CH = 4'(CHANNELS - 1);

    state_t                r_state;
    state_t                w_next;
    logic [CHANNELS-1:0]   r_sync1;
    logic [CHANNELS-1:0]   r_sync2;
    logic                  r_prev;
    logic [31:0]           r_cnt;
    logic [31:0]           r_per;
    logic [31:0]           r_hi;
    logic                  r_tmo_flag;

    logic [15:0]           w_sync_pad;
    logic                  w_sel;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_timeout;

    // Padding to 16 bits lets the 4-bit channel index select without a width mismatch.
    assign w_sync_pad = 16'(r_sync2);
    assign w_sel      = w_sync_pad[active_ch];
    assign w_rise     = w_sel & ~r_prev;
    assign w_fall     = ~w_sel & r_prev;
    assign w_timeout  = (r_cnt == TIMEOUT);

    assign done    = (r_state == S_STORE);
    assign done_ch = done ? active_ch : 4'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Edges win over timeout; dropping enable wins over both.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (enable) w_next = S_SETTLE;
            S_SETTLE: w_next = enable ? S_ARM : S_IDLE;
            S_ARM: begin
                if (!enable)        w_next = S_IDLE;
                else if (w_rise)    w_next = S_HIGH;
                else if (w_timeout) w_next = S_STORE;
            end
            S_HIGH: begin
                if (!enable)        w_next = S_IDLE;
                else if (w_fall)    w_next = S_LOW;
                else if (w_timeout) w_next = S_STORE;
            end
            S_LOW: begin
                if (!enable)                   w_next = S_IDLE;
                else if (w_rise || w_timeout)  w_next = S_STORE;
            end
            S_STORE:  w_next = enable ? S_SETTLE : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= 1'b0;
            r_cnt      <= '0;
            r_per      <= '0;
            r_hi       <= '0;
            r_tmo_flag <= 1'b0;
            period     <= '0;
            width      <= '0;
            valid      <= '0;
            tmo        <= '0;
            active_ch  <= '0;
        end else begin
            r_sync1 <= SIGNALS;
            r_sync2 <= r_sync1;
            // In SETTLE this loads prev from the newly selected channel, so the
            // level change across a channel switch never shows up as an edge.
            r_prev  <= w_sel;
            case (r_state)
                S_IDLE, S_SETTLE: r_cnt <= '0;
                S_ARM: begin
                    if (w_rise) begin
                        // The rise cycle counts as the first cycle of the measurement.
                        r_cnt <= 32'd1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                        if (w_timeout) begin
                            r_per      <= TIMEOUT;
                            r_hi       <= w_sel ? TIMEOUT : 32'd0;
                            r_tmo_flag <= 1'b1;
                        end
                    end
                end
                S_HIGH: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (w_fall) begin
                        r_hi <= r_cnt;
                    end else if (w_timeout) begin
                        r_per      <= TIMEOUT;
                        r_hi       <= w_sel ? TIMEOUT : 32'd0;
                        r_tmo_flag <= 1'b1;
                    end
                end
                S_LOW: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (w_rise) begin
                        r_per      <= r_cnt;
                        r_tmo_flag <= 1'b0;
                    end else if (w_timeout) begin
                        r_per      <= TIMEOUT;
                        r_hi       <= w_sel ? TIMEOUT : 32'd0;
                        r_tmo_flag <= 1'b1;
                    end
                end
                S_STORE: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (active_ch == 4'(i)) begin
                            period[32*i +: 32] <= r_per;
                            width[32*i +: 32]  <= r_hi;
                            valid[i]           <= 1'b1;
                            tmo[i]             <= r_tmo_flag;
                        end
                    end
                    active_ch <= (active_ch == LAST_CH) ? 4'd0 : active_ch + 4'd1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule
